// File: rtl/retire_trace_tx.sv
// Retirement trace transmitter: captures one normalised record per retired
// instruction into a FIFO and streams it to a trace sink over valid/ready.
module retire_trace_tx #(
    parameter int DEPTH     = 8,
    parameter int SEQ_W     = 16,
    parameter int MAX_INSTR = 50
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             retire_valid,
    input  logic [31:0]      retire_pc,
    input  logic [31:0]      retire_instr,
    input  logic [4:0]       retire_rd,
    input  logic             retire_rd_we,
    input  logic [31:0]      retire_rd_val,
    input  logic [2:0]       retire_type,
    output logic             trace_valid,
    input  logic             trace_ready,
    output logic [SEQ_W-1:0] trace_seq,
    output logic [31:0]      trace_pc,
    output logic [31:0]      trace_instr,
    output logic [4:0]       trace_rd,
    output logic [31:0]      trace_rd_val,
    output logic [2:0]       trace_type,
    output logic             overflow,
    output logic [15:0]      drop_cnt,
    output logic             illegal_type,
    output logic             done
);

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [31:0] LIMIT    = MAX_INSTR;
    localparam logic [2:0]  TYPE_S   = 3'd2;
    localparam logic [2:0]  TYPE_B   = 3'd3;

    typedef struct packed {
        logic [SEQ_W-1:0] seq;
        logic [31:0]      pc;
        logic [31:0]      instr;
        logic [4:0]       rd;
        logic [31:0]      rd_val;
        logic [2:0]       typ;
    } rec_t;

    rec_t             r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [SEQ_W-1:0] r_seq;
    logic [31:0]      r_remain;
    logic             r_done;
    logic             r_overflow;
    logic             r_illegal;
    logic [15:0]      r_drop_cnt;

    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_capture;
    logic             w_push;
    logic             w_drop;
    logic             w_no_rd;
    rec_t             w_rec;
    rec_t             w_head;

    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop     = !w_empty && trace_ready;
    assign w_capture = retire_valid && !r_done;
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign w_push    = w_capture && (!w_full || w_pop);
    assign w_drop    = w_capture && !w_push;

    assign w_no_rd   = !retire_rd_we || (retire_rd == 5'd0) ||
                       (retire_type == TYPE_S) || (retire_type == TYPE_B);

    always_comb begin
        w_rec        = '0;
        w_rec.seq    = r_seq;
        w_rec.pc     = retire_pc;
        w_rec.instr  = retire_instr;
        w_rec.rd     = w_no_rd ? 5'd0 : retire_rd;
        w_rec.rd_val = w_no_rd ? 32'd0 : retire_rd_val;
        w_rec.typ    = retire_type;
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= w_rec;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    // Sequence numbers are consumed by every capture, so drops leave a gap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_seq      <= '0;
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
            r_illegal  <= 1'b0;
        end else if (w_capture) begin
            r_seq <= r_seq + {{(SEQ_W-1){1'b0}}, 1'b1};
            if (retire_type[2:1] == 2'b11) begin
                r_illegal <= 1'b1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_cnt != 16'hFFFF) begin
                    r_drop_cnt <= r_drop_cnt + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_remain <= LIMIT;
            r_done   <= 1'b0;
        end else if (w_capture && (LIMIT != 32'd0)) begin
            r_remain <= r_remain - 32'd1;
            if (r_remain == 32'd1) begin
                r_done <= 1'b1;
            end
        end
    end

    assign w_head       = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

    assign trace_valid  = !w_empty;
    assign trace_seq    = w_head.seq;
    assign trace_pc     = w_head.pc;
    assign trace_instr  = w_head.instr;
    assign trace_rd     = w_head.rd;
    assign trace_rd_val = w_head.rd_val;
    assign trace_type   = w_head.typ;
    assign overflow     = r_overflow;
    assign drop_cnt     = r_drop_cnt;
    assign illegal_type = r_illegal;
    assign done         = r_done;

endmodule

// File: tb/tb_retire_trace_tx.sv
// Scoreboard bench for retire_trace_tx: a queue-based reference model predicts
// delivered records and status; a negedge monitor compares DUT output to it.
module tb_retire_trace_tx;

    localparam int DEPTH = 8;
    localparam int SEQ_W = 16;
    localparam int MAXI  = 50;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             retire_valid = 1'b0;
    logic [31:0]      retire_pc = '0;
    logic [31:0]      retire_instr = '0;
    logic [4:0]       retire_rd = '0;
    logic             retire_rd_we = 1'b0;
    logic [31:0]      retire_rd_val = '0;
    logic [2:0]       retire_type = '0;
    logic             trace_ready = 1'b0;
    logic             trace_valid;
    logic [SEQ_W-1:0] trace_seq;
    logic [31:0]      trace_pc;
    logic [31:0]      trace_instr;
    logic [4:0]       trace_rd;
    logic [31:0]      trace_rd_val;
    logic [2:0]       trace_type;
    logic             overflow;
    logic [15:0]      drop_cnt;
    logic             illegal_type;
    logic             done;

    retire_trace_tx #(.DEPTH(DEPTH), .SEQ_W(SEQ_W), .MAX_INSTR(MAXI)) dut (
        .clk(clk), .reset(reset),
        .retire_valid(retire_valid), .retire_pc(retire_pc), .retire_instr(retire_instr),
        .retire_rd(retire_rd), .retire_rd_we(retire_rd_we), .retire_rd_val(retire_rd_val),
        .retire_type(retire_type),
        .trace_valid(trace_valid), .trace_ready(trace_ready), .trace_seq(trace_seq),
        .trace_pc(trace_pc), .trace_instr(trace_instr), .trace_rd(trace_rd),
        .trace_rd_val(trace_rd_val), .trace_type(trace_type),
        .overflow(overflow), .drop_cnt(drop_cnt), .illegal_type(illegal_type), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] seq;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  rd;
        logic [31:0] val;
        logic [2:0]  typ;
    } rec_t;

    rec_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   n_deliv = 0;
    int   last_seq = -1;

    int          m_cnt = 0;
    int          m_caps = 0;
    logic [15:0] m_seq = '0;
    logic [15:0] m_drop = '0;
    bit          m_done = 0;
    bit          m_ovf = 0;
    bit          m_ill = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: occupancy count plus queue of expected records.
    initial forever begin
        @(posedge clk or negedge reset);
        if (!reset) begin
            m_cnt = 0; m_caps = 0; m_seq = '0; m_drop = '0;
            m_done = 0; m_ovf = 0; m_ill = 0;
            exp_q.delete();
        end else begin
            bit pop;
            pop = (m_cnt > 0) && trace_ready;
            if (retire_valid && !m_done) begin
                rec_t r;
                bit kill;
                kill = !retire_rd_we || retire_rd == 0 || retire_type == 2 || retire_type == 3;
                r.seq = m_seq; r.pc = retire_pc; r.instr = retire_instr;
                r.rd = kill ? 5'd0 : retire_rd;
                r.val = kill ? 32'd0 : retire_rd_val;
                r.typ = retire_type;
                m_seq = m_seq + 16'd1;
                m_caps++;
                if (retire_type >= 6) m_ill = 1;
                if (m_cnt < DEPTH || pop) begin
                    exp_q.push_back(r);
                    m_cnt++;
                end else begin
                    m_ovf = 1;
                    if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
                end
                if (MAXI != 0 && m_caps == MAXI) m_done = 1;
            end
            if (pop) m_cnt--;
        end
    end

    initial forever begin
        @(negedge clk);
        if (reset) begin
            chk("valid", trace_valid, m_cnt > 0);
            chk("overflow", overflow, m_ovf);
            chk("drop_cnt", drop_cnt, m_drop);
            chk("illegal", illegal_type, m_ill);
            chk("done", done, m_done);
            if (trace_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rec", 1, 0);
                end else begin
                    chk("seq", trace_seq, exp_q[0].seq);
                    chk("pc", trace_pc, exp_q[0].pc);
                    chk("instr", trace_instr, exp_q[0].instr);
                    chk("rd", trace_rd, exp_q[0].rd);
                    chk("rd_val", trace_rd_val, exp_q[0].val);
                    chk("type", trace_type, exp_q[0].typ);
                    if (trace_ready) begin
                        last_seq = int'(trace_seq);
                        void'(exp_q.pop_front());
                        n_deliv++;
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ret(input logic [31:0] pc, input logic [31:0] ins, input logic [4:0] rd,
                           input logic we, input logic [31:0] val, input logic [2:0] typ);
        retire_valid = 1'b1; retire_pc = pc; retire_instr = ins;
        retire_rd = rd; retire_rd_we = we; retire_rd_val = val; retire_type = typ;
    endtask

    task automatic rand_ret();
        set_ret($urandom, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                $urandom, 3'($urandom_range(0, 7)));
    endtask

    task automatic do_reset();
        retire_valid = 1'b0;
        trace_ready = 1'b0;
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
    endtask

    task automatic drain();
        retire_valid = 1'b0;
        trace_ready = 1'b1;
        for (int i = 0; i < 100 && trace_valid; i++) step();
        chk("drain_timeout", trace_valid, 0);
        chk("drain_sb_empty", exp_q.size(), 0);
    endtask

    initial begin
        int n0;
        do_reset();
        chk("rst_valid", trace_valid, 0);
        chk("rst_seq", trace_seq, 0);
        chk("rst_pc", trace_pc, 0);
        chk("rst_rd_val", trace_rd_val, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_drop", drop_cnt, 0);
        chk("rst_ill", illegal_type, 0);
        chk("rst_done", done, 0);

        trace_ready = 1'b1;
        set_ret(32'h100, 32'h00500093, 5'd1, 1'b1, 32'd5, 3'd1);
        step(); retire_valid = 1'b0;
        @(negedge clk);
        chk("single_valid", trace_valid, 1);
        chk("single_seq", trace_seq, 0);
        chk("single_rd", trace_rd, 1);
        chk("single_val", trace_rd_val, 5);
        step();
        @(negedge clk);
        chk("single_empty", trace_valid, 0);
        step();

        set_ret(32'h104, 32'h0, 5'd0, 1'b1, 32'hDEAD, 3'd0);
        step(); retire_valid = 1'b0;
        @(negedge clk);
        chk("norm_rd0_rd", trace_rd, 0);
        chk("norm_rd0_val", trace_rd_val, 0);
        step();
        set_ret(32'h108, 32'h0, 5'd7, 1'b1, 32'h1234, 3'd3);
        step(); retire_valid = 1'b0;
        @(negedge clk);
        chk("norm_b_rd", trace_rd, 0);
        chk("norm_b_val", trace_rd_val, 0);
        step();
        set_ret(32'h10C, 32'h0, 5'd3, 1'b1, 32'd77, 3'd7);
        step(); retire_valid = 1'b0;
        @(negedge clk);
        chk("illegal_flag", illegal_type, 1);
        chk("illegal_valid", trace_valid, 1);
        chk("illegal_rd_val", trace_rd_val, 77);
        step();
        drain();

        do_reset();
        trace_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin rand_ret(); step(); end
        retire_valid = 1'b0;
        step();
        chk("bp_overflow", overflow, 1);
        chk("bp_drop", drop_cnt, 2);
        n0 = n_deliv;
        drain();
        chk("bp_delivered", n_deliv - n0, 8);
        chk("bp_last_seq", last_seq, 7);
        rand_ret();
        step(); retire_valid = 1'b0;
        @(negedge clk);
        chk("bp_seq_gap", trace_seq, 10);
        step();
        trace_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin rand_ret(); step(); end
        retire_valid = 1'b0;
        step();
        n0 = n_deliv;
        rand_ret(); trace_ready = 1'b1;
        step();
        retire_valid = 1'b0; trace_ready = 1'b0;
        step();
        chk("full_pp_drop", drop_cnt, 2);
        drain();
        chk("full_pp_deliv", n_deliv - n0, 9);
        chk("full_pp_last", last_seq, 19);

        do_reset();
        n0 = n_deliv;
        for (int i = 0; i < 400 && !done; i++) begin
            if ($urandom_range(0, 9) < 7) rand_ret(); else retire_valid = 1'b0;
            trace_ready = ($urandom_range(0, 9) < 6);
            step();
        end
        drain();
        chk("rand_done", done, 1);
        chk("rand_captures", (n_deliv - n0) + int'(drop_cnt), 50);

        do_reset();
        trace_ready = 1'b1;
        n0 = n_deliv;
        for (int i = 0; i < 55; i++) begin rand_ret(); step(); end
        drain();
        chk("lim_deliv", n_deliv - n0, 50);
        chk("lim_last", last_seq, 49);
        chk("lim_drop", drop_cnt, 0);
        chk("lim_done", done, 1);

        do_reset();
        trace_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin rand_ret(); step(); end
        retire_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("arst_valid", trace_valid, 0);
        chk("arst_seq", trace_seq, 0);
        step(); step();
        reset = 1'b1;
        step();
        trace_ready = 1'b1;
        rand_ret();
        step(); retire_valid = 1'b0;
        @(negedge clk);
        chk("arst_new_valid", trace_valid, 1);
        chk("arst_new_seq", trace_seq, 0);
        step();
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
